// File: rtl/nios2_system_keys_in.sv
// Avalon-MM input PIO: synchronises (and optionally debounces) external pins,
// latches selected edges into a W1C capture register and raises a maskable irq.
module nios2_system_keys_in #(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 0,
  parameter int   EDGE_TYPE       = 1,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL}};

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_prev_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr;
  logic             wr;

  assign wr = chipselect & ~write_n;

  // Two-flop synchroniser; idle level preload avoids a fake edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync2_next(in_port, sync1_q);
    end
  end

  function automatic logic [WIDTH-1:0] sync2_next(input logic [WIDTH-1:0] pins,
                                                  input logic [WIDTH-1:0] s1);
    sync2_next = s1;
  endfunction

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign db = sync2_q;
    end else begin : g_debounce
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [CNT_W-1:0] cnt_q;
        logic             db_bit_q;
        // Any cycle back at the debounced level restarts the stability count.
        always_ff @(posedge clk) begin
          if (reset) begin
            cnt_q    <= '0;
            db_bit_q <= IDLE_LEVEL;
          end else if (sync2_q[gi] == db_bit_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            db_bit_q <= sync2_q[gi];
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        assign db[gi] = db_bit_q;
      end
    end
  endgenerate

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_hit = db & ~db_prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_hit = ~db & db_prev_q;
    end else begin : g_any
      assign edge_hit = db ^ db_prev_q;
    end
  endgenerate

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = &{1'b0, writedata[31:WIDTH]};
    end
  endgenerate

  assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    irqmask_d = irqmask_q;
    if (wr && address == 2'd2) irqmask_d = writedata[WIDTH-1:0];
    // Set has priority over clear so an edge landing on a clear is kept.
    edgecap_d = (edgecap_q & ~clr) | edge_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_prev_q <= IDLE;
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      db_prev_q <= db;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = db;
      2'd2:    readdata[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata[WIDTH-1:0] = edgecap_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios2_system_keys_in.sv
// Directed bench: three instances cover N=0/falling, N=4/falling and N=0/any-edge.
module tb_nios2_system_keys_in;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs0, cs4, cs2;
  logic [3:0]  in0, in4, in2;
  logic [31:0] rd0, rd4, rd2;
  logic        irq0, irq4, irq2;
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  nios2_system_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)) u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs0), .write_n(write_n),
    .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));

  nios2_system_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)) u4 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs4), .write_n(write_n),
    .writedata(writedata), .in_port(in4), .readdata(rd4), .irq(irq4));

  nios2_system_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IDLE_LEVEL(1'b1)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs2), .write_n(write_n),
    .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_rd(input string tag, input int d, input logic [1:0] a,
                        input logic [31:0] exp);
    logic [31:0] v;
    address = a;
    #1;
    v = (d == 0) ? rd0 : (d == 4) ? rd4 : rd2;
    chk(tag, v, exp);
  endtask

  task automatic chk_irq(input string tag, input int d, input logic exp);
    logic v;
    v = (d == 0) ? irq0 : (d == 4) ? irq4 : irq2;
    chk(tag, {31'd0, v}, {31'd0, exp});
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
    address   = a;
    writedata = v;
    write_n   = 1'b0;
    cs0 = (d == 0);
    cs4 = (d == 4);
    cs2 = (d == 2);
    step(1);
    write_n = 1'b1;
    cs0 = 1'b0; cs4 = 1'b0; cs2 = 1'b0;
    writedata = '0;
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; write_n = 1'b1; writedata = '0;
    cs0 = 1'b0; cs4 = 1'b0; cs2 = 1'b0;
    in0 = 4'hF; in4 = 4'hF; in2 = 4'hF;
    step(2);
    reset = 1'b0;

    // Reset state
    chk_rd("rst_data", 0, 2'd0, 32'h0000000F);
    chk_rd("rst_resv", 0, 2'd1, 32'h0);
    chk_rd("rst_mask", 0, 2'd2, 32'h0);
    chk_rd("rst_cap", 0, 2'd3, 32'h0);
    chk_irq("rst_irq", 0, 1'b0);
    step(3);
    chk_rd("post_rst_cap0", 0, 2'd3, 32'h0);
    chk_rd("post_rst_cap4", 4, 2'd3, 32'h0);
    chk_rd("post_rst_cap2", 2, 2'd3, 32'h0);
    chk_irq("post_rst_irq", 0, 1'b0);

    // Ignored writes
    wr(0, 2'd0, 32'h0);
    chk_rd("data_ro", 0, 2'd0, 32'h0000000F);
    wr(0, 2'd1, 32'hFFFFFFFF);
    chk_rd("resv_ro", 0, 2'd1, 32'h0);

    // N=0 falling edge latency and W1C
    wr(0, 2'd2, 32'h2);
    chk_rd("mask_rb", 0, 2'd2, 32'h2);
    in0 = 4'hD;
    step(2);
    chk_rd("n0_data_k1", 0, 2'd0, 32'hD);
    chk_rd("n0_cap_k1", 0, 2'd3, 32'h0);
    chk_irq("n0_irq_k1", 0, 1'b0);
    step(1);
    chk_rd("n0_cap_k2", 0, 2'd3, 32'h2);
    chk_irq("n0_irq_k2", 0, 1'b1);
    wr(0, 2'd3, 32'h2);
    chk_rd("n0_cap_clr", 0, 2'd3, 32'h0);
    chk_irq("n0_irq_clr", 0, 1'b0);

    // Mask gating
    wr(0, 2'd2, 32'h0);
    in0 = 4'h5;
    step(3);
    chk_rd("mask_cap8", 0, 2'd3, 32'h8);
    chk_irq("mask_irq_off", 0, 1'b0);
    wr(0, 2'd2, 32'h8);
    chk_irq("mask_irq_on", 0, 1'b1);
    wr(0, 2'd2, 32'h0);
    chk_irq("mask_irq_off2", 0, 1'b0);
    chk_rd("mask_cap_kept", 0, 2'd3, 32'h8);
    wr(0, 2'd3, 32'h8);
    chk_rd("mask_cap_clr", 0, 2'd3, 32'h0);

    // Set/clear collision on bit 1
    in0 = 4'h7;
    step(3);
    in0 = 4'h5;
    step(3);
    chk_rd("coll_pending", 0, 2'd3, 32'h2);
    in0 = 4'h7;
    step(3);
    in0 = 4'h5;
    step(2);
    wr(0, 2'd3, 32'h2);
    chk_rd("coll_set_wins", 0, 2'd3, 32'h2);
    wr(0, 2'd3, 32'h2);
    chk_rd("coll_clr", 0, 2'd3, 32'h0);

    // N=4 debounce: 3-cycle glitch rejected, 4+ cycle low accepted
    wr(4, 2'd2, 32'h1);
    in4 = 4'hE;
    step(3);
    in4 = 4'hF;
    step(8);
    chk_rd("glitch_data", 4, 2'd0, 32'hF);
    chk_rd("glitch_cap", 4, 2'd3, 32'h0);
    chk_irq("glitch_irq", 4, 1'b0);
    in4 = 4'hE;
    step(5);
    chk_rd("db_k4", 4, 2'd0, 32'hF);
    step(1);
    chk_rd("db_k5", 4, 2'd0, 32'hE);
    chk_rd("db_cap_k5", 4, 2'd3, 32'h0);
    step(1);
    chk_rd("db_cap_k6", 4, 2'd3, 32'h1);
    chk_irq("db_irq_k6", 4, 1'b1);

    // Any-edge capture on bit 2
    wr(2, 2'd2, 32'h4);
    in2 = 4'hB;
    step(3);
    chk_rd("any_fall_cap", 2, 2'd3, 32'h4);
    chk_irq("any_fall_irq", 2, 1'b1);
    wr(2, 2'd3, 32'h4);
    chk_rd("any_clr", 2, 2'd3, 32'h0);
    step(6);
    in2 = 4'hF;
    step(2);
    chk_rd("any_rise_k1", 2, 2'd3, 32'h0);
    step(1);
    chk_rd("any_rise_cap", 2, 2'd3, 32'h4);
    chk_rd("any_data", 2, 2'd0, 32'hF);

    // Reset mid-debounce with a pending capture on u4
    in4 = 4'h6;
    step(3);
    reset = 1'b1;
    in4 = 4'hF;
    step(1);
    chk_irq("midrst_irq", 4, 1'b0);
    chk_rd("midrst_cap", 4, 2'd3, 32'h0);
    reset = 1'b0;
    step(1);
    chk_rd("midrst_data", 4, 2'd0, 32'hF);
    chk_rd("midrst_mask", 4, 2'd2, 32'h0);
    step(10);
    chk_rd("midrst_cap_late", 4, 2'd3, 32'h0);
    chk_rd("midrst_data_late", 4, 2'd0, 32'hF);
    chk_irq("midrst_irq_late", 4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
